// File: rtl/dbg_uart_pkg.sv
// Shared types, frame geometry and checksum helper for the debug UART transmit path.
// CHK is the two's complement of the payload byte sum; the sync byte is excluded.
package dbg_uart_pkg;

   typedef enum logic [1:0] {IDLE, SEND, DONE} frame_state_t;
   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;

   localparam int         FRAME_BYTES   = 14;
   localparam int         PAYLOAD_BYTES = 12;
   localparam logic [7:0] DEFAULT_SYNC  = 8'hA5;

   function automatic logic [7:0] calc_chk(input logic [8*PAYLOAD_BYTES-1:0] payload);
      logic [7:0] sum;
      sum = 8'h00;
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
         sum = sum + payload[8*i +: 8];
      end
      return 8'h00 - sum;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser, LSB first; TX drops one cycle after byte_valid is taken.
// byte_ready is high when idle and in the last stop-bit cycle, so a held byte follows with no gap.
module uart_tx_byte
   import dbg_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic [7:0] byte_data,
   output logic       TX
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   byte_state_t   r_state;
   logic [CW-1:0] r_clk_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          w_bit_end;

   assign w_bit_end  = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
   assign byte_ready = (r_state == B_IDLE) || ((r_state == B_STOP) && w_bit_end);
   assign TX         = r_tx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= B_IDLE;
         r_clk_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CW'(1);
         case (r_state)
            B_IDLE: begin
               r_clk_cnt <= '0;
               if (byte_valid) begin
                  r_state <= B_START;
                  r_shift <= byte_data;
                  r_tx    <= 1'b0;
               end
            end
            B_START: if (w_bit_end) begin
               r_state   <= B_DATA;
               r_bit_idx <= '0;
               r_tx      <= r_shift[0];
            end
            B_DATA: if (w_bit_end) begin
               if (r_bit_idx == 3'd7) begin
                  r_state <= B_STOP;
                  r_tx    <= 1'b1;
               end else begin
                  // the bit on the line is r_shift[0]; the next one is r_shift[1]
                  r_bit_idx <= r_bit_idx + 3'd1;
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_tx      <= r_shift[1];
               end
            end
            B_STOP: if (w_bit_end) begin
               if (byte_valid) begin
                  r_state <= B_START;
                  r_shift <= byte_data;
                  r_tx    <= 1'b0;
               end else begin
                  r_state <= B_IDLE;
               end
            end
            default: r_state <= B_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/dbg_frame_tx.sv
// Debug bus snapshot framer: SYNC, addr, rdata, wdata (MSB byte first), CHK as 14 back-to-back 8N1 bytes.
// Start bit one cycle after accept; snap_ready only in IDLE, so snapshots wait while a frame is on the line.
module dbg_frame_tx
   import dbg_uart_pkg::*;
#(
   parameter int         CLK_FREQ  = 100000000,
   parameter int         BAUD      = 115200,
   parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        snap_valid,
   output logic        snap_ready,
   input  logic [31:0] snap_addr,
   input  logic [31:0] snap_rdata,
   input  logic [31:0] snap_wdata,
   output logic        TX,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam logic [3:0] CHK_IDX      = 4'(FRAME_BYTES - 1);
   localparam logic [3:0] END_IDX      = 4'(FRAME_BYTES);

   frame_state_t r_state;
   logic [95:0]  r_snap;
   logic [7:0]   r_chk;
   logic [3:0]   r_byte_idx;
   logic         r_busy;
   logic [15:0]  r_frame_cnt;
   logic         w_accept;
   logic         w_byte_vld;
   logic         w_byte_rdy;
   logic [7:0]   w_byte_dat;

   assign snap_ready = (r_state == IDLE) && rst;
   assign w_accept   = snap_valid && snap_ready;
   // SYNC is handed over in the accept cycle itself so the start bit leaves one cycle later
   assign w_byte_vld = w_accept || (rst && (r_state == SEND) && (r_byte_idx != END_IDX));
   assign busy       = r_busy;
   assign frame_cnt  = r_frame_cnt;

   always_comb begin
      w_byte_dat = SYNC_BYTE;
      if (r_byte_idx == CHK_IDX) begin
         w_byte_dat = r_chk;
      end else if (r_byte_idx != 4'd0) begin
         w_byte_dat = r_snap[95:88];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_snap      <= '0;
         r_chk       <= '0;
         r_byte_idx  <= '0;
         r_busy      <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_snap     <= {snap_addr, snap_rdata, snap_wdata};
               r_chk      <= calc_chk({snap_addr, snap_rdata, snap_wdata});
               r_byte_idx <= 4'd1;
               r_busy     <= 1'b1;
               r_state    <= SEND;
            end
            SEND: if (w_byte_rdy) begin
               // ready with nothing left to hand over is the final stop-bit cycle of CHK
               if (r_byte_idx == END_IDX) begin
                  r_state <= DONE;
               end else begin
                  r_byte_idx <= r_byte_idx + 4'd1;
                  r_snap     <= {r_snap[87:0], 8'h00};
               end
            end
            DONE: begin
               r_state     <= IDLE;
               r_busy      <= 1'b0;
               r_byte_idx  <= '0;
               r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clk       (clk),
      .rst       (rst),
      .byte_valid(w_byte_vld),
      .byte_ready(w_byte_rdy),
      .byte_data (w_byte_dat),
      .TX        (TX)
   );

endmodule

// File: doc/dbg_frame_tx.md
Name: dbg_frame_tx

Overview:
- Transmit side of the debug UART link.
- Accepts a snapshot of the memory bus (address, read data, write data) through a valid/ready handshake.
- Serialises the snapshot as a fixed 14-byte framed packet on TX: 8N1, LSB first, with a sync byte and a checksum.
- Sits beside the debug UART receiver on the free-running board clock. It feeds host-side tooling that reconstructs bus activity.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bits/s. Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 2).
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  board clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- snap_valid  in  1  snapshot offered.
- snap_ready  out  1  block can accept a snapshot this cycle.
- snap_addr  in  32  bus address to report.
- snap_rdata  in  32  bus read data to report.
- snap_wdata  in  32  bus write data to report.
- TX  out  1  serial line; idles high.
- busy  out  1  frame in progress.
- frame_cnt  out  16  completed frames; wraps.

Behaviour:
- Reset (rst==0 at a clock edge):
  - Next cycle: TX=1, busy=0, snap_ready=0, frame_cnt=0, FSM=IDLE, bit/byte counters 0.
  - snap_ready rises on the first cycle after rst returns high.
- Reset mid-frame: frame aborted immediately, no partial completion, frame_cnt unchanged by the aborted frame, TX=1 the next cycle.
- Handshake:
  - snap_ready = (state==IDLE) && rst.
  - Accept on snap_valid && snap_ready: register all 96 snapshot bits, compute checksum, busy=1, snap_ready=0 from the next cycle.
  - Inputs are ignored while busy. snap_valid without ready has no effect.
- Frame order, 14 bytes: SYNC_BYTE, addr[31:24], addr[23:16], addr[15:8], addr[7:0], rdata bytes MSB first (4), wdata bytes MSB first (4), CHK.
- CHK = (0 - sum of the 12 payload bytes) mod 256, so (sum of payload + CHK) mod 256 == 0. The sync byte is excluded from the checksum.
- Byte format: start bit 0, data[0]..data[7], stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
- Byte FSM (inside serialiser): IDLE -> START -> DATA (8 bits, bit index 0..7) -> STOP -> next START with no idle gap, or IDLE after the last byte.
- Frame FSM: IDLE -> SEND (byte index 0..13) -> DONE (1 cycle: frame_cnt++, busy=0) -> IDLE.
- Latency:
  - TX falls (start bit of SYNC) on the cycle after acceptance.
  - Frame occupies 140*CLKS_PER_BIT cycles of line time.
  - Then DONE, then IDLE with snap_ready=1. A new frame can start no earlier than 2 cycles after the last stop bit ends, with TX high throughout.
- Simultaneous events: snap_valid arriving in the DONE cycle is not accepted (ready=0). It is accepted in the following IDLE cycle if still held.
- frame_cnt wraps 16'hFFFF -> 16'h0000.
- TX is registered (glitch-free); no combinational path from inputs to TX.

Decomposition:
- Package dbg_uart_pkg:
  - frame_state_t enum {IDLE, SEND, DONE}.
  - byte_state_t enum {B_IDLE, B_START, B_DATA, B_STOP}.
  - FRAME_BYTES=14, PAYLOAD_BYTES=12, DEFAULT_SYNC=8'hA5.
- Sub-module uart_tx_byte (clk, rst, CLKS_PER_BIT param, byte_valid/byte_ready/byte_data in, TX out):
  - Single-byte 8N1 serialiser.
  - byte_ready pulses during the stop bit's final cycle so the next byte starts back-to-back.
  - dbg_frame_tx holds the frame FSM, byte mux, checksum and counter.

Test Plan (CLK_FREQ=400, BAUD=100 -> CLKS_PER_BIT=4):
- Reset: hold rst=0 for 3 cycles with snap_valid=1 -> TX=1, busy=0, snap_ready=0, frame_cnt=0 throughout. snap_ready=1 one cycle after release.
- Single frame: addr=0x00000010, rdata=0x12345678, wdata=0x0 -> decoded bytes A5 00 00 00 10 12 34 56 78 00 00 00 00 DC.
  - TX low on the cycle after acceptance; 560 line cycles; frame_cnt=1; busy low after DONE.
- Bit timing: frame above -> every start/data/stop bit exactly 4 cycles wide; no idle gap between bytes 0..13.
- Back-to-back: snap_valid held high with a changing snapshot -> second frame starts exactly 2 cycles after the first frame's last stop bit. Inputs changed mid-frame do not alter frame 1. Checksums valid.
- Reset mid-frame: assert rst=0 during byte 5 -> TX=1 next cycle, frame_cnt stays at its prior value, a fresh frame after release is correct.
- Wrap: force frame_cnt=0xFFFF (or send 65536 frames in a fast sim) -> next completion gives 0x0000.
